// File: rtl/analog_csync_gen.sv
// analog_csync_gen
//   Builds an active-low composite sync for an analog YPbPr/RGB output stage
//   from separate hsync/vsync. Once line timing has been measured and is
//   stable, the vertical interval can be serrated and optionally followed by
//   equalizing lines. Otherwise the output falls back to a plain XOR of hsync
//   and vsync.
// Ports:
//   clk, reset        single clock, asynchronous active-high reset
//   ce_pix            pixel-rate enable for counters and state
//   mode[1:0]         0 = XOR, 1 = serrated vsync, 2/3 = serrated + equalizing
//   hsync_in/vsync_in source syncs; HS_POL/VS_POL give their active levels
//   de_in             source data enable
//   hsync_o/vsync_o   active-high syncs, registered
//   csync_n           composite sync, active-low, registered
//   de_o              registered de_in
//   locked            line length measured and stable for two lines
module analog_csync_gen #(
    parameter logic        HS_POL   = 1'b1,
    parameter logic        VS_POL   = 1'b1,
    parameter int unsigned EQ_LINES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic [1:0] mode,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       de_in,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       csync_n,
    output logic       de_o,
    output logic       locked
);

    typedef enum logic [1:0] {ST_NORMAL, ST_VSERR, ST_EQ} state_t;

    localparam logic       EQ_EN   = (EQ_LINES > 0);
    localparam logic [7:0] EQ_LOAD = 8'(EQ_LINES);

    state_t      state_q, state_d;
    logic [11:0] hpos_q, hpos_d;
    logic [11:0] line_len_q, line_len_d;
    logic [11:0] hsw_q, hsw_d;
    logic [1:0]  lock_cnt_q, lock_cnt_d;
    logic [7:0]  eq_cnt_q, eq_cnt_d;
    logic        hs_prev_q, hs_prev_d;
    logic        hsync_o_q, hsync_o_d;
    logic        vsync_o_q, vsync_o_d;
    logic        csync_n_q, csync_n_d;
    logic        de_o_q, de_o_d;
    logic        locked_q, locked_d;

    logic        hs_act, vs_act, hs_rise, hs_fall, hpos_sat, win_ok;
    logic [11:0] half, eqw;

    always_comb begin
        hs_act   = (hsync_in == HS_POL);
        vs_act   = (vsync_in == VS_POL);
        hs_rise  = ce_pix & hs_act & ~hs_prev_q;
        hs_fall  = ce_pix & ~hs_act & hs_prev_q;
        hpos_sat = (hpos_q == 12'hFFF);
        half     = line_len_q >> 1;
        eqw      = hsw_q >> 1;
        win_ok   = (hsw_q < half);

        hs_prev_d  = hs_prev_q;
        hpos_d     = hpos_q;
        line_len_d = line_len_q;
        hsw_d      = hsw_q;
        lock_cnt_d = lock_cnt_q;
        eq_cnt_d   = eq_cnt_q;
        state_d    = state_q;

        if (ce_pix) begin
            hs_prev_d = hs_act;
            if (hs_rise)        hpos_d = '0;
            else if (!hpos_sat) hpos_d = hpos_q + 12'd1;
        end

        if (hs_rise) begin
            line_len_d = hpos_q + 12'd1;
            if ((hpos_q + 12'd1 == line_len_q) && !hpos_sat)
                lock_cnt_d = (lock_cnt_q == 2'd2) ? 2'd2 : lock_cnt_q + 2'd1;
            else
                lock_cnt_d = '0;
        end
        // A line that never ends drops lock on the pixel it saturates.
        if (ce_pix && hpos_sat) lock_cnt_d = '0;

        if (hs_fall) hsw_d = hpos_q + 12'd1;

        locked_d = (lock_cnt_d == 2'd2);

        if (hs_rise) begin
            unique case (state_q)
                ST_NORMAL: begin
                    if (vs_act && locked_d && (mode != 2'd0)) state_d = ST_VSERR;
                end
                ST_VSERR: begin
                    if (mode == 2'd0) begin
                        state_d = ST_NORMAL;
                    end else if (!vs_act) begin
                        if (mode[1] && EQ_EN) begin
                            state_d  = ST_EQ;
                            eq_cnt_d = EQ_LOAD;
                        end else begin
                            state_d = ST_NORMAL;
                        end
                    end
                end
                ST_EQ: begin
                    // Loaded on entry, so reaching zero here ends the last EQ line.
                    eq_cnt_d = (eq_cnt_q == 8'd0) ? 8'd0 : eq_cnt_q - 8'd1;
                    if ((mode == 2'd0) || (eq_cnt_q <= 8'd1)) begin
                        state_d  = ST_NORMAL;
                        eq_cnt_d = '0;
                    end
                end
                default: state_d = ST_NORMAL;
            endcase
        end
        if (!locked_d) state_d = ST_NORMAL;

        hsync_o_d = hs_act;
        vsync_o_d = vs_act;
        de_o_d    = de_in;

        // Windows are evaluated against the post-edge position and state so the
        // registered csync lines up with the registered hpos.
        if ((mode == 2'd0) || !locked_d) begin
            csync_n_d = ~(hs_act ^ vs_act);
        end else if ((state_d == ST_VSERR) && win_ok) begin
            csync_n_d = ~((hpos_d < half - hsw_q) ||
                          ((hpos_d >= half) && (hpos_d < line_len_q - hsw_q)));
        end else if ((state_d == ST_EQ) && win_ok) begin
            csync_n_d = ~((hpos_d < eqw) ||
                          ((hpos_d >= half) && (hpos_d < half + eqw)));
        end else begin
            csync_n_d = ~hs_act;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_NORMAL;
            hpos_q     <= '0;
            line_len_q <= '0;
            hsw_q      <= '0;
            lock_cnt_q <= '0;
            eq_cnt_q   <= '0;
            hs_prev_q  <= 1'b0;
            hsync_o_q  <= 1'b0;
            vsync_o_q  <= 1'b0;
            csync_n_q  <= 1'b1;
            de_o_q     <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hpos_q     <= hpos_d;
            line_len_q <= line_len_d;
            hsw_q      <= hsw_d;
            lock_cnt_q <= lock_cnt_d;
            eq_cnt_q   <= eq_cnt_d;
            hs_prev_q  <= hs_prev_d;
            hsync_o_q  <= hsync_o_d;
            vsync_o_q  <= vsync_o_d;
            csync_n_q  <= csync_n_d;
            de_o_q     <= de_o_d;
            locked_q   <= locked_d;
        end
    end

    assign hsync_o = hsync_o_q;
    assign vsync_o = vsync_o_q;
    assign csync_n = csync_n_q;
    assign de_o    = de_o_q;
    assign locked  = locked_q;

endmodule

// File: tb/tb_analog_csync_gen.sv
// Testbench for analog_csync_gen: 800-pixel lines, 96-pixel hsync.
module tb_analog_csync_gen;

    logic       clk = 1'b0;
    logic       reset, ce_pix, hsync_in, vsync_in, de_in;
    logic [1:0] mode;
    logic       hsync_o, vsync_o, csync_n, de_o, locked;

    int n_pass = 0;
    int n_tot  = 0;
    int ce_div = 1;
    logic line_lk;

    localparam int K_NONE = 0, K_NORM = 1, K_VSERR = 2, K_EQ = 3, K_XOR = 4;

    typedef struct {
        logic       hs, vs, de;
        logic [1:0] md;
        logic [4:0] exp; // {hsync_o, vsync_o, de_o, csync_n, locked}
    } vec_t;
    vec_t vecs[8];

    analog_csync_gen #(.HS_POL(1'b1), .VS_POL(1'b1), .EQ_LINES(3)) dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix), .mode(mode),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .csync_n(csync_n),
        .de_o(de_o), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One pixel: ce_pix low for ce_div-1 clocks, then high for one clock.
    task automatic step(input logic hs, input logic vs, input logic de);
        hsync_in = hs; vsync_in = vs; de_in = de;
        if (ce_div > 1) begin
            ce_pix = 1'b0;
            repeat (ce_div - 1) @(posedge clk);
            #1;
        end
        ce_pix = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_cs(input int kind, input int x, input logic vs);
        logic hs;
        hs = (x < 96);
        case (kind)
            K_NORM:  return !hs;
            K_VSERR: return !((x < 304) || (x >= 400 && x < 704));
            K_EQ:    return !((x < 48) || (x >= 400 && x < 448));
            default: return !(hs ^ vs);
        endcase
    endfunction

    task automatic run_line(input int len, input logic vs, input int kind, input string name);
        int bad, pbad, bad_x;
        logic hs, de;
        bad = 0; pbad = 0; bad_x = -1;
        for (int x = 0; x < len; x++) begin
            hs = (x < 96);
            de = (x >= 144 && x < 784);
            step(hs, vs, de);
            if (x == 0) line_lk = locked;
            if (kind != K_NONE && csync_n !== exp_cs(kind, x, vs)) begin
                if (bad == 0) bad_x = x;
                bad++;
            end
            if ({hsync_o, vsync_o, de_o} !== {hs, vs, de}) pbad++;
        end
        if (kind != K_NONE)
            check($sformatf("%s csync bad pixels (first x=%0d)", name, bad_x), bad, 0);
        check($sformatf("%s passthrough bad pixels", name), pbad, 0);
    endtask

    task automatic do_reset(input logic [1:0] md);
        mode = md; ce_pix = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; de_in = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {hsync_o, vsync_o, de_o, csync_n, locked}, 5'b00010);
        reset = 1'b0;
    endtask

    task automatic lock_up(input string name);
        run_line(800, 1'b0, K_NONE, {name, " l1"});
        run_line(800, 1'b0, K_NONE, {name, " l2"});
        run_line(800, 1'b0, K_NONE, {name, " l3"});
        check({name, " locked low at 2nd line edge"}, line_lk, 1'b0);
        run_line(800, 1'b0, K_NORM, {name, " l4 normal"});
        check({name, " locked at 3rd line edge"}, line_lk, 1'b1);
    endtask

    initial begin
        reset = 1'b1; ce_pix = 1'b0; mode = 2'd0;
        hsync_in = 1'b0; vsync_in = 1'b0; de_in = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 2'd0, 5'b00010};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 2'd1, 5'b10100};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 2'd2, 5'b11010};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 2'd3, 5'b01100};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 2'd1, 5'b00010};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 2'd0, 5'b01000};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 2'd0, 5'b11110};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 2'd2, 5'b10000};

        // Unlocked: registered passthrough and XOR composite.
        do_reset(2'd0);
        for (int i = 0; i < 8; i++) begin
            mode = vecs[i].md;
            step(vecs[i].hs, vecs[i].vs, vecs[i].de);
            check($sformatf("vector %0d outputs", i),
                  {hsync_o, vsync_o, de_o, csync_n, locked}, vecs[i].exp);
        end

        // Mode 1: lock, 3 serrated vsync lines, back to normal, then saturation.
        do_reset(2'd1);
        lock_up("m1");
        run_line(800, 1'b1, K_VSERR, "m1 vserr1");
        run_line(800, 1'b1, K_VSERR, "m1 vserr2");
        run_line(800, 1'b1, K_VSERR, "m1 vserr3");
        run_line(800, 1'b0, K_NORM,  "m1 after vsync");
        for (int i = 0; i < 3000; i++) step(1'b0, 1'b0, 1'b0);
        check("locked held before hpos saturates", locked, 1'b1);
        for (int i = 0; i < 1100; i++) step(1'b0, 1'b0, 1'b0);
        check("locked cleared by saturated hpos", locked, 1'b0);

        // Mode 2: serration then 3 equalizing lines, then normal.
        do_reset(2'd2);
        lock_up("m2");
        run_line(800, 1'b1, K_VSERR, "m2 vserr1");
        run_line(800, 1'b1, K_VSERR, "m2 vserr2");
        run_line(800, 1'b1, K_VSERR, "m2 vserr3");
        run_line(800, 1'b0, K_EQ,    "m2 eq1");
        run_line(800, 1'b0, K_EQ,    "m2 eq2");
        run_line(800, 1'b0, K_EQ,    "m2 eq3");
        run_line(800, 1'b0, K_NORM,  "m2 after eq");

        // Mode 0 while locked: XOR even inside vsync.
        do_reset(2'd0);
        run_line(800, 1'b0, K_XOR, "m0 l1");
        run_line(800, 1'b0, K_XOR, "m0 l2");
        run_line(800, 1'b0, K_XOR, "m0 l3");
        run_line(800, 1'b0, K_XOR, "m0 l4");
        check("m0 locked", line_lk, 1'b1);
        run_line(800, 1'b1, K_XOR, "m0 vsync1");
        run_line(800, 1'b1, K_XOR, "m0 vsync2");

        // Line length change in the middle of serration.
        do_reset(2'd1);
        lock_up("chg");
        run_line(800, 1'b1, K_VSERR, "chg vserr1");
        run_line(801, 1'b1, K_VSERR, "chg vserr 801");
        run_line(800, 1'b1, K_XOR,   "chg xor fallback");
        check("chg locked dropped", line_lk, 1'b0);

        // Reset mid-line with ce_pix every 2nd clock, then relock.
        ce_div = 2;
        do_reset(2'd1);
        lock_up("ce2");
        for (int x = 0; x <= 50; x++) step(x < 96, 1'b1, 1'b1);
        check("ce2 pre-reset outputs", {hsync_o, vsync_o, de_o, csync_n, locked}, 5'b11101);
        #3;
        reset = 1'b1;
        #1;
        check("ce2 async reset outputs", {hsync_o, vsync_o, de_o, csync_n, locked}, 5'b00010);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("ce2 held reset outputs", {hsync_o, vsync_o, de_o, csync_n, locked}, 5'b00010);
        reset = 1'b0;
        for (int x = 51; x < 800; x++) step(x < 96, 1'b0, 1'b0);
        lock_up("ce2 relock");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/analog_csync_gen.md
ANALOG_CSYNC_GEN -- requirements
Module: analog_csync_gen

Interface
REQ-001 SHALL have parameter HS_POL, default 1, hsync_in active level.
REQ-002 SHALL have parameter VS_POL, default 1, vsync_in active level.
REQ-003 SHALL have parameter EQ_LINES, default 3, post-vsync equalizing line count (0 disables).
REQ-004 SHALL have port clk  input  1  system/pixel clock; single clock domain.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port ce_pix  input  1  pixel-rate enable; counters and state advance only when 1.
REQ-007 SHALL have port mode  input  2  0=simple XOR, 1=serrated vsync, 2=serrated plus equalizing, 3=treated as 2.
REQ-008 SHALL have port hsync_in  input  1  source horizontal sync.
REQ-009 SHALL have port vsync_in  input  1  source vertical sync.
REQ-010 SHALL have port de_in  input  1  source data enable.
REQ-011 SHALL have port hsync_o  output  1  hs_act registered; always active-high.
REQ-012 SHALL have port vsync_o  output  1  vs_act registered; always active-high.
REQ-013 SHALL have port csync_n  output  1  composite sync, active-low, for the downstream YPbPr/RGB output stage.
REQ-014 SHALL have port de_o  output  1  de_in registered.
REQ-015 SHALL have port locked  output  1  line timing measured and stable.

Function
REQ-016 SHALL derive hs_act = (hsync_in == HS_POL) and vs_act = (vsync_in == VS_POL).
REQ-017 SHALL register all outputs on every clk edge, independent of ce_pix; latency from inputs to outputs is exactly 1 clk.
REQ-018 SHALL keep a 12-bit hpos that, on ce_pix with an hs_act rising edge (hs_act=1, previous sampled hs_act=0), loads 0; otherwise it increments, saturating at 4095.
REQ-019 SHALL, at each hs_act rising edge, capture line_len = hpos+1 (12-bit); if the value equals the previous line_len and hpos has not saturated, it increments lock_cnt (saturating at 2); otherwise it clears lock_cnt.
REQ-020 SHALL, at each hs_act falling edge on ce_pix, capture hsw = hpos+1 (hsync width in pixels).
REQ-021 SHALL assert locked when lock_cnt==2; a saturated hpos SHALL clear lock_cnt and locked on the same ce_pix.
REQ-022 SHALL define half = line_len>>1 and eqw = hsw>>1, with all comparisons unsigned 12-bit; if hsw >= half, serrated and equalizing windows SHALL fall back to NORMAL behaviour.
REQ-023 SHALL implement a state machine NORMAL, VSERR, EQ, with state changes only at hs_act rising edges on ce_pix.
REQ-024 SHALL transition NORMAL->VSERR when vs_act=1, locked=1 and mode!=0.
REQ-025 SHALL transition VSERR->EQ when vs_act=0, mode>=2 and EQ_LINES>0, loading eq_cnt=EQ_LINES; otherwise, when vs_act=0, it SHALL transition VSERR->NORMAL.
REQ-026 SHALL decrement eq_cnt at each hsync edge while in EQ, and SHALL transition EQ->NORMAL when eq_cnt reaches 0 after that edge, so that exactly EQ_LINES lines are spent in EQ.
REQ-027 SHALL force state NORMAL on the same ce_pix that locked deasserts, or on the next hsync edge if mode becomes 0.
REQ-028 SHALL, when mode=0 or locked=0, drive csync_n = ~(hs_act ^ vs_act).
REQ-029 SHALL, in NORMAL with mode!=0 and locked=1, drive csync_n = ~hs_act.
REQ-030 SHALL, in VSERR, drive csync active (0) when hpos < half-hsw, or half <= hpos < line_len-hsw; otherwise 1.
REQ-031 SHALL, in EQ, drive csync active (0) when hpos < eqw, or half <= hpos < half+eqw; otherwise 1.
REQ-032 SHALL resolve a vsync edge coincident with an hsync edge using the new vs_act value.

Reset
REQ-033 SHALL, while reset=1, asynchronously force hsync_o=0, vsync_o=0, de_o=0, csync_n=1, locked=0, state=NORMAL, and hpos, line_len, hsw, lock_cnt and eq_cnt to 0.
REQ-034 SHALL, on reset release mid-frame, require two further matching line measurements before locked rises.

Verification
REQ-035 SHALL verify: ce_pix=1, line 800, hsw 96, mode=1 -> locked rises at the 3rd hsync edge; csync_n equals ~hs_act delayed 1 clk.
REQ-036 SHALL verify: same timing, vsync 3 lines -> in VSERR csync_n=0 for hpos 0..303 and 400..703, =1 elsewhere, for exactly 3 lines.
REQ-037 SHALL verify: mode=2, EQ_LINES=3 -> after vsync, 3 lines with csync_n=0 at hpos 0..47 and 400..447 only, then NORMAL.
REQ-038 SHALL verify: mode=0 with vsync active -> csync_n = ~(hs^vs), i.e. csync_n=1 during hsync inside vsync.
REQ-039 SHALL verify: line length changes 800->801 mid-VSERR -> locked drops at that edge, state=NORMAL, and XOR fallback applies.
REQ-040 SHALL verify: reset asserted mid-line with ce_pix toggling every 2nd clk -> outputs take reset values immediately; relock occurs after 3 hsync edges.
